mulalu: RTL

- Multi-cycle multiply/divide unit in the EX stage, directly downstream of the single-cycle ALU.
- Consumes the ALU's mulalu_func/mulalu_sign request, hi_write/lo_write strobes and operands.
- Owns the architectural HI/LO registers and feeds them back to the ALU for MFHI/MFLO.
- Raises stall to freeze the pipeline while an operation runs.

---
 rtl/mulalu_pkg.sv | 33 +++
 rtl/mulalu_if.sv | 28 ++
 rtl/mulalu_divcore.sv | 65 ++++++
 rtl/mulalu.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mulalu_pkg.sv
// mulalu_pkg: shared widths, function codes, FSM state type and sign helper
// for the multi-cycle multiply/divide unit (mulalu) and its divider core.
package mulalu_pkg;

    localparam int W_DATA = 32;
    localparam int W_FUNC = 5;
    localparam int CNT_W  = 6;

    localparam logic [W_FUNC-1:0] FUNC_NONE = 5'b00000;
    localparam logic [W_FUNC-1:0] FUNC_MUL  = 5'b01000;
    localparam logic [W_FUNC-1:0] FUNC_DIV  = 5'b01001;

    // LO value written for any divide by zero
    localparam logic [W_DATA-1:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mulalu_state_t;

    // Magnitude of v when treated as signed (sgn = 1), otherwise v itself.
    // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [W_DATA-1:0] abs_val(input logic [W_DATA-1:0] v,
                                                  input logic sgn);
        if (sgn && v[W_DATA-1]) begin
            abs_val = ~v + 32'd1;
        end else begin
            abs_val = v;
        end
    endfunction

endpackage

// File: rtl/mulalu_if.sv
// mulalu_if: request/result bundle between the EX-stage ALU and mulalu.
//   master (ALU side): drives func, sign, source_a, source_b, hi_write,
//                      lo_write, flush; receives stall, hi, lo.
//   slave  (mulalu) : the mirror image.
interface mulalu_if;
    import mulalu_pkg::*;

    logic [W_FUNC-1:0] func;
    logic              sign;
    logic [W_DATA-1:0] source_a;
    logic [W_DATA-1:0] source_b;
    logic              hi_write;
    logic              lo_write;
    logic              flush;
    logic              stall;
    logic [W_DATA-1:0] hi;
    logic [W_DATA-1:0] lo;

    modport master (
        output func, sign, source_a, source_b, hi_write, lo_write, flush,
        input  stall, hi, lo
    );

    modport slave (
        input  func, sign, source_a, source_b, hi_write, lo_write, flush,
        output stall, hi, lo
    );
endinterface

// File: rtl/mulalu_divcore.sv
// mulalu_divcore: unsigned restoring divider, one quotient bit per step.
//   clk, rst  : clock, synchronous active-high reset
//   load      : clear remainder, load dividend into the quotient register
//   step      : perform one shift/trial-subtract iteration
//   dividend, divisor : unsigned operands (divisor must be held while stepping)
//   quotient, remainder : current contents of the shift registers
module mulalu_divcore
    import mulalu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [W_DATA-1:0] dividend,
    input  logic [W_DATA-1:0] divisor,
    output logic [W_DATA-1:0] quotient,
    output logic [W_DATA-1:0] remainder
);

    logic [W_DATA-1:0] rem_q, rem_d;
    logic [W_DATA-1:0] quo_q, quo_d;
    logic [W_DATA:0]   shifted_s;
    logic [W_DATA+1:0] diff_s;

    // Next-state for the remainder/quotient pair: load, one iteration, or hold
    always_comb begin
        rem_d     = rem_q;
        quo_d     = quo_q;
        // Partial remainder shifted left, pulling in the next dividend bit
        shifted_s = {rem_q, quo_q[W_DATA-1]};
        // Extra top bit acts as the borrow flag of the trial subtraction
        diff_s    = {1'b0, shifted_s} - {2'b00, divisor};
        if (load) begin
            rem_d = {W_DATA{1'b0}};
            quo_d = dividend;
        end else if (step) begin
            if (diff_s[W_DATA+1]) begin
                // Borrow: restore, quotient bit 0 (shifted value < divisor < 2^32)
                rem_d = shifted_s[W_DATA-1:0];
                quo_d = {quo_q[W_DATA-2:0], 1'b0};
            end else begin
                rem_d = diff_s[W_DATA-1:0];
                quo_d = {quo_q[W_DATA-2:0], 1'b1};
            end
        end else begin
            rem_d = rem_q;
            quo_d = quo_q;
        end
    end

    // Divider shift registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= {W_DATA{1'b0}};
            quo_q <= {W_DATA{1'b0}};
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mulalu.sv
// mulalu: multi-cycle multiply/divide unit owning the HI/LO registers.
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : mulalu_if.slave -- func/sign/source_a/source_b request,
//          hi_write/lo_write (MTHI/MTLO), flush, stall, hi, lo
// Optional build macro MULALU_FAST_MUL_EN: single-cycle signed 33x33
// multiplier (accept goes straight to DONE). Without it, multiplication is a
// shift-add over MUL_STEPS cycles sharing the BUSY counter. Division always
// uses the DIV_STEPS-cycle restoring divider.
module mulalu
    import mulalu_pkg::*;
#(
    parameter int DIV_STEPS = 32,
    parameter int MUL_STEPS = 32
) (
    input  logic      clk,
    input  logic      rst,
    mulalu_if.slave   bus
);

    mulalu_state_t     state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              is_div_q, is_div_d;
    logic              q_neg_q, q_neg_d;   // negate product / quotient
    logic              r_neg_q, r_neg_d;   // negate remainder
    logic              div0_q, div0_d;
    logic [W_DATA-1:0] a_raw_q, a_raw_d;   // raw dividend for divide-by-zero HI
    logic [W_DATA-1:0] hi_q, hi_d;
    logic [W_DATA-1:0] lo_q, lo_d;
    logic [W_DATA-1:0] mcand_q, mcand_d;
    logic [63:0]       prod_q, prod_d;

    logic              req_s;
    logic              stall_s;
    logic              div_load_s;
    logic              div_step_s;
    logic [W_DATA-1:0] abs_a_s, abs_b_s;
    logic [W_DATA:0]   mul_sum_s;
    logic [63:0]       mul_next_s;
    logic [63:0]       mul_res_s;
    logic [W_DATA-1:0] div_quo_s, div_rem_s;
    logic [W_DATA-1:0] res_hi_s, res_lo_s;
`ifdef MULALU_FAST_MUL_EN
    logic signed [63:0] fa_s, fb_s;
`endif

    mulalu_divcore u_divcore (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load_s),
        .step      (div_step_s),
        .dividend  (abs_a_s),
        .divisor   (abs_b_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s)
    );

    // Operand magnitudes, one shift-add step, and the sign-corrected results
    always_comb begin
        abs_a_s = abs_val(bus.source_a, bus.sign);
        abs_b_s = abs_val(bus.source_b, bus.sign);
        if (prod_q[0]) begin
            mul_sum_s = {1'b0, prod_q[63:32]} + {1'b0, mcand_q};
        end else begin
            mul_sum_s = {1'b0, prod_q[63:32]};
        end
        mul_next_s = {mul_sum_s, prod_q[31:1]};
        if (q_neg_q) begin
            mul_res_s = ~prod_q + 64'd1;
        end else begin
            mul_res_s = prod_q;
        end
        if (!is_div_q) begin
            res_hi_s = mul_res_s[63:32];
            res_lo_s = mul_res_s[31:0];
        end else if (div0_q) begin
            res_hi_s = a_raw_q;
            res_lo_s = DIV0_LO;
        end else begin
            res_lo_s = q_neg_q ? (~div_quo_s + 32'd1) : div_quo_s;
            res_hi_s = r_neg_q ? (~div_rem_s + 32'd1) : div_rem_s;
        end
    end

    // FSM next state, stall, operand capture and HI/LO update
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        is_div_d   = is_div_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        div0_d     = div0_q;
        a_raw_d    = a_raw_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        mcand_d    = mcand_q;
        prod_d     = prod_q;
        stall_s    = 1'b0;
        div_load_s = 1'b0;
        div_step_s = 1'b0;
        req_s      = (bus.func != FUNC_NONE) && !bus.flush;
`ifdef MULALU_FAST_MUL_EN
        fa_s = {{32{bus.sign & bus.source_a[31]}}, bus.source_a};
        fb_s = {{32{bus.sign & bus.source_b[31]}}, bus.source_b};
`endif
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    stall_s  = 1'b1;
                    is_div_d = (bus.func == FUNC_DIV);
                    a_raw_d  = bus.source_a;
                    div0_d   = (bus.source_b == 32'd0);
                    q_neg_d  = bus.sign & (bus.source_a[31] ^ bus.source_b[31]);
                    r_neg_d  = bus.sign & bus.source_a[31];
                    if (bus.func == FUNC_DIV) begin
                        div_load_s = 1'b1;
                        count_d    = CNT_W'(DIV_STEPS - 1);
                        state_d    = BUSY;
                    end else begin
`ifdef MULALU_FAST_MUL_EN
                        // Sign-extended 33-bit operands; low 64 bits of product
                        prod_d  = fa_s * fb_s;
                        q_neg_d = 1'b0;
                        state_d = DONE;
`else
                        mcand_d = abs_a_s;
                        prod_d  = {32'd0, abs_b_s};
                        count_d = CNT_W'(MUL_STEPS - 1);
                        state_d = BUSY;
`endif
                    end
                end else if (!bus.flush) begin
                    if (bus.hi_write) begin
                        hi_d = bus.source_a;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (bus.lo_write) begin
                        lo_d = bus.source_a;
                    end else begin
                        lo_d = lo_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    stall_s = 1'b1;
                    if (is_div_q) begin
                        div_step_s = 1'b1;
                    end else begin
                        prod_d = mul_next_s;
                    end
                    if (count_q == {CNT_W{1'b0}}) begin
                        state_d = DONE;
                    end else begin
                        count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            DONE: begin
                // Request still presented here is the finishing instruction
                state_d = IDLE;
                if (!bus.flush) begin
                    hi_d = res_hi_s;
                    lo_d = res_lo_s;
                end else begin
                    hi_d = hi_q;
                    lo_d = lo_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, control and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= {CNT_W{1'b0}};
            is_div_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            div0_q   <= 1'b0;
            a_raw_q  <= {W_DATA{1'b0}};
            hi_q     <= {W_DATA{1'b0}};
            lo_q     <= {W_DATA{1'b0}};
            mcand_q  <= {W_DATA{1'b0}};
            prod_q   <= 64'd0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            is_div_q <= is_div_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            div0_q   <= div0_d;
            a_raw_q  <= a_raw_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
        end
    end

    assign bus.stall = stall_s;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule
